// File: rtl/clock_set_controller.sv
// -----------------------------------------------------------------------------
// clock_set_controller
//
// Time-setting sequencer for the 24 h clock datapath. Debounced Mode/Up
// button levels drive a RUN -> SET_HOURS -> SET_MINUTES -> RUN state machine
// that emits single-cycle increment strobes, a seconds-clear strobe, a run
// gate for the 1 Hz timekeeping path and a per-digit blink mask.
//
// Optional feature macro: CLKSET_REPEAT_EN
//   defined   : holding Up auto-repeats the active Inc strobe
//               (first repeat REPEAT_DELAY_CYC cycles after the press strobe,
//               then every REPEAT_RATE_CYC cycles).
//   undefined : exactly one Inc strobe per Up rising edge; no repeat logic.
//
// Ports:
//   Clk_100M      in   system clock, 100 MHz
//   Reset_n       in   asynchronous reset, active low
//   Tick_1Hz      in   one-cycle pulse per second from the prescaler
//   Button_Mode   in   debounced Mode button level
//   Button_Up     in   debounced Up button level
//   Run_Enable    out  1 = timekeeping advances on Tick_1Hz
//   Inc_Hours     out  one-cycle strobe: hours +1
//   Inc_Minutes   out  one-cycle strobe: minutes +1 (no carry into hours)
//   Clear_Seconds out  one-cycle strobe: seconds <= 0
//   Blink_Mask    out  [3] hours tens, [2] hours units,
//                      [1] minutes tens, [0] minutes units (1 = blank)
//   Mode          out  00 RUN, 01 SET_HOURS, 10 SET_MINUTES
// -----------------------------------------------------------------------------
module clock_set_controller #(
  parameter int REPEAT_DELAY_CYC = 50_000_000,
  parameter int REPEAT_RATE_CYC  = 10_000_000,
  parameter int BLINK_HALF_CYC   = 25_000_000,
  parameter int TIMEOUT_TICKS    = 10
) (
  input  logic       Clk_100M,
  input  logic       Reset_n,
  input  logic       Tick_1Hz,
  input  logic       Button_Mode,
  input  logic       Button_Up,
  output logic       Run_Enable,
  output logic       Inc_Hours,
  output logic       Inc_Minutes,
  output logic       Clear_Seconds,
  output logic [3:0] Blink_Mask,
  output logic [1:0] Mode
);

  localparam int TO_W = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;
  localparam int BL_W = (BLINK_HALF_CYC > 1) ? $clog2(BLINK_HALF_CYC) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_TICKS - 1);
  localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_HALF_CYC - 1);

  typedef enum logic [1:0] {
    ST_RUN         = 2'b00,
    ST_SET_HOURS   = 2'b01,
    ST_SET_MINUTES = 2'b10
  } state_t;

  state_t            state;
  state_t            state_next;
  logic              mode_prev;
  logic              up_prev;
  logic              mode_rise;
  logic              up_rise;
  logic              in_set;
  logic              timeout_hit;
  logic              repeat_fire;
  logic              inc_fire;
  logic              state_change;
  logic [TO_W-1:0]   to_cnt;
  logic [BL_W-1:0]   blink_cnt;
  logic              blink_phase;

  // Edge detection, next-state and strobe qualification
  always_comb begin
    mode_rise  = Button_Mode & ~mode_prev;
    up_rise    = Button_Up & ~up_prev;
    in_set     = (state != ST_RUN);
    // The count reaches TIMEOUT_TICKS on this tick. Any button edge or Inc
    // strobe in the same cycle restarts the count instead.
    timeout_hit = in_set && Tick_1Hz && !mode_rise && !up_rise &&
                  !repeat_fire && (to_cnt == TO_LAST);
    state_next = state;
    if (mode_rise) begin
      case (state)
        ST_RUN:       state_next = ST_SET_HOURS;
        ST_SET_HOURS: state_next = ST_SET_MINUTES;
        default:      state_next = ST_RUN;
      endcase
    end else if (timeout_hit) begin
      state_next = ST_RUN;
    end
    state_change = (state_next != state);
    // Mode wins over a simultaneous Up edge or repeat.
    inc_fire = in_set && !mode_rise && (up_rise || repeat_fire);
  end

  always_ff @(posedge Clk_100M or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= ST_RUN;
    end else begin
      state <= state_next;
    end
  end

  // Registered strobes and stored button levels
  always_ff @(posedge Clk_100M or negedge Reset_n) begin
    if (!Reset_n) begin
      mode_prev     <= 1'b0;
      up_prev       <= 1'b0;
      Inc_Hours     <= 1'b0;
      Inc_Minutes   <= 1'b0;
      Clear_Seconds <= 1'b0;
    end else begin
      mode_prev     <= Button_Mode;
      up_prev       <= Button_Up;
      Inc_Hours     <= inc_fire && (state == ST_SET_HOURS);
      Inc_Minutes   <= inc_fire && (state == ST_SET_MINUTES);
      // Seconds restart on entry to SET_HOURS and on every return to RUN.
      Clear_Seconds <= state_change &&
                       ((state_next == ST_SET_HOURS) || (state_next == ST_RUN));
    end
  end

  // Inactivity timeout counter (Tick_1Hz pulses in SET states)
  always_ff @(posedge Clk_100M or negedge Reset_n) begin
    if (!Reset_n) begin
      to_cnt <= '0;
    end else if (!in_set || state_change || mode_rise || up_rise || inc_fire) begin
      to_cnt <= '0;
    end else if (Tick_1Hz) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  // Blink phase generator; held at phase 0 while Up is down so the digit
  // being adjusted stays visible.
  always_ff @(posedge Clk_100M or negedge Reset_n) begin
    if (!Reset_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (!in_set || state_change || Button_Up) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BL_LAST) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt   <= blink_cnt + 1'b1;
    end
  end

`ifdef CLKSET_REPEAT_EN
  localparam int HOLD_MAX = (REPEAT_DELAY_CYC > REPEAT_RATE_CYC) ?
                            REPEAT_DELAY_CYC : REPEAT_RATE_CYC;
  localparam int HOLD_W   = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam logic [HOLD_W-1:0] DELAY_LAST = HOLD_W'(REPEAT_DELAY_CYC - 1);
  localparam logic [HOLD_W-1:0] RATE_LAST  = HOLD_W'(REPEAT_RATE_CYC - 1);

  logic [HOLD_W-1:0] hold_cnt;
  logic              hold_active;
  logic              hold_repeating;
  logic              hold_match;

  // hold_active marks a press that was accepted in the current SET state;
  // the counter first measures the initial delay, then the repeat period.
  always_comb begin
    hold_match  = hold_repeating ? (hold_cnt == RATE_LAST) : (hold_cnt == DELAY_LAST);
    repeat_fire = hold_active && Button_Up && hold_match;
  end

  always_ff @(posedge Clk_100M or negedge Reset_n) begin
    if (!Reset_n) begin
      hold_cnt       <= '0;
      hold_active    <= 1'b0;
      hold_repeating <= 1'b0;
    end else if (!in_set || state_change || !Button_Up) begin
      hold_cnt       <= '0;
      hold_active    <= 1'b0;
      hold_repeating <= 1'b0;
    end else if (up_rise) begin
      hold_cnt       <= '0;
      hold_active    <= 1'b1;
      hold_repeating <= 1'b0;
    end else if (hold_active) begin
      if (hold_match) begin
        hold_cnt       <= '0;
        hold_repeating <= 1'b1;
      end else begin
        hold_cnt       <= hold_cnt + 1'b1;
      end
    end
  end
`else
  assign repeat_fire = 1'b0;
`endif

  // Output decode
  always_comb begin
    Mode       = state;
    Run_Enable = (state == ST_RUN);
    Blink_Mask = 4'b0000;
    if (blink_phase) begin
      if (state == ST_SET_HOURS) begin
        Blink_Mask = 4'b1100;
      end else if (state == ST_SET_MINUTES) begin
        Blink_Mask = 4'b0011;
      end
    end
  end

endmodule

// File: tb/tb_clock_set_controller.sv
// -----------------------------------------------------------------------------
// tb_clock_set_controller
//
// Self-checking bench for clock_set_controller with short parameters
// (REPEAT_DELAY_CYC=8, REPEAT_RATE_CYC=4, BLINK_HALF_CYC=6, TIMEOUT_TICKS=3).
// Directed vector table, hand-written multi-cycle sequences and a randomized
// run compared against a behavioural reference model.
// -----------------------------------------------------------------------------
module tb_clock_set_controller;

  localparam int DLY  = 8;
  localparam int RATE = 4;
  localparam int HALF = 6;
  localparam int TMO  = 3;
`ifdef CLKSET_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif
  localparam logic [9:0] RST_PAT = 10'b00_1_0_0_0_0000;

  logic       Clk_100M = 1'b0;
  logic       Reset_n;
  logic       Tick_1Hz;
  logic       Button_Mode;
  logic       Button_Up;
  logic       Run_Enable;
  logic       Inc_Hours;
  logic       Inc_Minutes;
  logic       Clear_Seconds;
  logic [3:0] Blink_Mask;
  logic [1:0] Mode;

  int passed = 0;
  int total  = 0;

  clock_set_controller #(
    .REPEAT_DELAY_CYC(DLY),
    .REPEAT_RATE_CYC (RATE),
    .BLINK_HALF_CYC  (HALF),
    .TIMEOUT_TICKS   (TMO)
  ) dut (
    .Clk_100M     (Clk_100M),
    .Reset_n      (Reset_n),
    .Tick_1Hz     (Tick_1Hz),
    .Button_Mode  (Button_Mode),
    .Button_Up    (Button_Up),
    .Run_Enable   (Run_Enable),
    .Inc_Hours    (Inc_Hours),
    .Inc_Minutes  (Inc_Minutes),
    .Clear_Seconds(Clear_Seconds),
    .Blink_Mask   (Blink_Mask),
    .Mode         (Mode)
  );

  always #5 Clk_100M = ~Clk_100M;

  // Reference model: mode as 0/1/2, press age in cycles, ticks since last
  // activity, cycles since the blink timer restarted.
  int         m_mode, m_age, m_ticks, m_bt;
  bit         m_pm, m_pu;
  logic       e_ih, e_im, e_clr;
  logic [3:0] e_mask;

  task automatic model_step(input bit bm, input bit bu, input bit tk);
    bit mr, ur, setst, rep, inc, tohit, changed;
    int age1, nmode, nbt, phase;
    mr    = bm && !m_pm;
    ur    = bu && !m_pu;
    setst = (m_mode != 0);
    age1  = (m_age >= 0) ? m_age + 1 : -1;
    rep   = REP_EN && setst && bu && (m_age >= 0) && (age1 >= DLY) &&
            (((age1 - DLY) % RATE) == 0);
    inc   = setst && !mr && (ur || rep);
    tohit = setst && tk && !mr && !ur && !rep && (m_ticks + 1 == TMO);
    nmode = m_mode;
    if (mr) nmode = (m_mode + 1) % 3;
    else if (tohit) nmode = 0;
    changed = (nmode != m_mode);
    nbt   = (!setst || changed || bu) ? 0 : m_bt + 1;
    phase = (nbt / HALF) % 2;
    m_pm    <= bm;
    m_pu    <= bu;
    m_mode  <= nmode;
    m_age   <= (!setst || changed || !bu) ? -1 : (ur ? 0 : age1);
    m_ticks <= (!setst || changed || ur || inc) ? 0 : (tk ? m_ticks + 1 : m_ticks);
    m_bt    <= nbt;
    e_ih    <= inc && (m_mode == 1);
    e_im    <= inc && (m_mode == 2);
    e_clr   <= changed && (nmode != 2);
    e_mask  <= (phase == 1 && nmode == 1) ? 4'b1100 :
               (phase == 1 && nmode == 2) ? 4'b0011 : 4'b0000;
  endtask

  always @(posedge Clk_100M or negedge Reset_n) begin
    if (!Reset_n) begin
      m_mode <= 0; m_age <= -1; m_ticks <= 0; m_bt <= 0;
      m_pm <= 1'b0; m_pu <= 1'b0;
      e_ih <= 1'b0; e_im <= 1'b0; e_clr <= 1'b0; e_mask <= 4'b0000;
    end else begin
      model_step(Button_Mode, Button_Up, Tick_1Hz);
    end
  end

  function automatic logic [9:0] outs();
    return {Mode, Run_Enable, Inc_Hours, Inc_Minutes, Clear_Seconds, Blink_Mask};
  endfunction

  function automatic logic [9:0] model_outs();
    return {m_mode[1:0], (m_mode == 0), e_ih, e_im, e_clr, e_mask};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b, expected %b", name, act, exp);
  endtask

  // Apply one cycle of inputs at a falling edge; return at the next one.
  task automatic cyc(input bit bm, input bit bu, input bit tk);
    Button_Mode = bm;
    Button_Up   = bu;
    Tick_1Hz    = tk;
    @(negedge Clk_100M);
  endtask

  typedef struct {
    bit         bm, bu, tk;
    logic [9:0] exp;
  } vec_t;

  function automatic vec_t mk(bit bm, bit bu, bit tk, logic [1:0] md, bit run,
                              bit ih, bit im, bit clr, logic [3:0] mask);
    vec_t v;
    v.bm = bm; v.bu = bu; v.tk = tk;
    v.exp = {md, run, ih, im, clr, mask};
    return v;
  endfunction

  vec_t       tbl[20];
  logic [31:0] rep_got, rep_exp, hrs_got;
  int         bad;
  bit         rbm, rbu;

  initial begin
    Reset_n = 1'b0; Button_Mode = 1'b0; Button_Up = 1'b0; Tick_1Hz = 1'b0;
    repeat (3) @(negedge Clk_100M);
    chk("reset_state", outs(), RST_PAT);
    Reset_n = 1'b1;

    // Directed vectors from reset: mode cycling, Inc strobes, Up ignored in
    // RUN, simultaneous edges, timeout from SET_MINUTES.
    tbl[0]  = mk(1,0,0, 2'd1,0,0,0,1,4'h0);
    tbl[1]  = mk(1,0,0, 2'd1,0,0,0,0,4'h0);
    tbl[2]  = mk(0,0,0, 2'd1,0,0,0,0,4'h0);
    tbl[3]  = mk(0,1,0, 2'd1,0,1,0,0,4'h0);
    tbl[4]  = mk(0,0,0, 2'd1,0,0,0,0,4'h0);
    tbl[5]  = mk(1,0,0, 2'd2,0,0,0,0,4'h0);
    tbl[6]  = mk(0,1,0, 2'd2,0,0,1,0,4'h0);
    tbl[7]  = mk(0,0,0, 2'd2,0,0,0,0,4'h0);
    tbl[8]  = mk(1,0,0, 2'd0,1,0,0,1,4'h0);
    tbl[9]  = mk(0,1,0, 2'd0,1,0,0,0,4'h0);
    tbl[10] = mk(0,0,0, 2'd0,1,0,0,0,4'h0);
    tbl[11] = mk(1,1,0, 2'd1,0,0,0,1,4'h0);
    tbl[12] = mk(0,0,0, 2'd1,0,0,0,0,4'h0);
    tbl[13] = mk(1,1,0, 2'd2,0,0,0,0,4'h0);
    tbl[14] = mk(0,1,0, 2'd2,0,0,0,0,4'h0);
    tbl[15] = mk(0,0,0, 2'd2,0,0,0,0,4'h0);
    tbl[16] = mk(0,0,1, 2'd2,0,0,0,0,4'h0);
    tbl[17] = mk(0,0,1, 2'd2,0,0,0,0,4'h0);
    tbl[18] = mk(0,0,1, 2'd0,1,0,0,1,4'h0);
    tbl[19] = mk(0,0,0, 2'd0,1,0,0,0,4'h0);
    for (int i = 0; i < 20; i++) begin
      cyc(tbl[i].bm, tbl[i].bu, tbl[i].tk);
      chk($sformatf("vec%0d", i), outs(), tbl[i].exp);
    end

    // Blink in SET_HOURS: 0000/1100 every HALF cycles, held off by Up.
    cyc(1,0,0);
    chk("blink_entry", Blink_Mask, 4'b0000);
    for (int j = 1; j <= 24; j++) begin
      cyc(0,0,0);
      chk("blink_sh", Blink_Mask, ((j / HALF) % 2 == 1) ? 4'b1100 : 4'b0000);
    end
    for (int j = 0; j < 14; j++) begin
      cyc(0,1,0);
      chk("blink_up_held", Blink_Mask, 4'b0000);
    end
    cyc(0,0,0);
    cyc(1,0,0);
    cyc(0,0,0);
    cyc(1,0,0);
    chk("back_to_run", {Mode, Run_Enable}, 3'b001);
    for (int j = 0; j < 14; j++) begin
      cyc(0,0,0);
      chk("blink_run", Blink_Mask, 4'b0000);
    end

    // Auto-repeat in SET_MINUTES: Up held 20 cycles.
    cyc(1,0,0); cyc(0,0,0); cyc(1,0,0); cyc(0,0,0);
    chk("in_set_minutes", Mode, 2'd2);
    rep_got = '0; hrs_got = '0;
    for (int i = 0; i < 24; i++) begin
      cyc(0, (i < 20), 0);
      rep_got[i+1] = Inc_Minutes;
      hrs_got[i+1] = Inc_Hours;
    end
    rep_exp = REP_EN ? 32'h0002_2202 : 32'h0000_0002;
    chk("repeat_minutes", rep_got, rep_exp);
    chk("repeat_no_hours", hrs_got, 32'h0);

    // Timeout restart: Up edge after two ticks needs three more ticks.
    cyc(1,0,0); cyc(0,0,0); cyc(1,0,0); cyc(0,0,0);
    chk("in_set_hours", Mode, 2'd1);
    cyc(0,0,1); cyc(0,0,1);
    cyc(0,1,0);
    cyc(0,0,1); cyc(0,0,1);
    chk("timeout_restart", {Mode, Run_Enable}, 3'b010);
    cyc(0,0,1);
    chk("timeout_exit", outs(), 10'b00_1_0_0_1_0000);

    // Asynchronous reset in the middle of an Up hold.
    cyc(1,0,0); cyc(0,0,0); cyc(1,0,0); cyc(0,0,0);
    for (int i = 0; i < 10; i++) cyc(0,1,0);
    #2 Reset_n = 1'b0;
    #1 chk("async_reset", outs(), RST_PAT);
    @(negedge Clk_100M);
    @(negedge Clk_100M);
    Reset_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(0, 1, ($urandom_range(0, 3) == 0));
      if (outs() !== RST_PAT) bad++;
    end
    chk("post_reset_quiet", bad, 0);
    cyc(1,1,0);
    chk("fresh_mode_press", outs(), 10'b01_0_0_0_1_0000);
    cyc(0,1,0);
    chk("held_up_no_inc", {Inc_Hours, Inc_Minutes}, 2'b00);
    cyc(0,0,0);

    // Randomized run against the reference model.
    rbm = 1'b0; rbu = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 11) == 0) rbm = ~rbm;
      if ($urandom_range(0, 9) == 0) rbu = ~rbu;
      cyc(rbm, rbu, ($urandom_range(0, 5) == 0));
      chk($sformatf("model_cyc%0d", i), outs(), model_outs());
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
